// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : parser_pkg
// Purpose : Shared types and constants for the parser key-extract stage.
// Revision: 1.0 - initial release
// ============================================================================
package parser_pkg;

    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_HDR_BEATS   = 8;
    localparam int DEF_FIELD_WIDTH = 16;

    localparam int HW_PER_BEAT = DEF_DATA_WIDTH / DEF_FIELD_WIDTH;
    localparam int BEAT_IDX_W  = $clog2(DEF_HDR_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EXTRACT = 2'd2,
        ST_OUTPUT  = 2'd3
    } st_t;

    typedef logic [DEF_FIELD_WIDTH-1:0] field_t;

endpackage
`default_nettype wire

// File: rtl/parser_hdr_buf.sv
`default_nettype none
// ============================================================================
// Module  : parser_hdr_buf
// Purpose : Header beat storage with a saturating received-beat count and a
//           single halfword read port (reads beyond the count return zero).
// Revision: 1.0 - initial release
// ============================================================================
module parser_hdr_buf
    import parser_pkg::*;
#(
    parameter int DATA_WIDTH       = 128,
    parameter int HDR_BEATS        = 8,
    parameter int FIELD_WIDTH      = 16,
    parameter int KEY_OFFSET_WIDTH = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [KEY_OFFSET_WIDTH-1:0] rd_offset,
    output field_t                      rd_field
);

    localparam int N_HW  = DATA_WIDTH / FIELD_WIDTH;
    localparam int HW_W  = $clog2(N_HW);
    localparam int BI_W  = KEY_OFFSET_WIDTH - HW_W;
    localparam int CNT_W = $clog2(HDR_BEATS + 1);

    // Halfword 0 of a beat sits in the most significant packed slot.
    logic [N_HW-1:0][FIELD_WIDTH-1:0] mem [HDR_BEATS];
    logic [CNT_W-1:0]                 cnt;
    logic                             room;
    logic [BI_W-1:0]                  beat_sel;
    logic [HW_W-1:0]                  hw_rev;

    assign room = (cnt < CNT_W'(HDR_BEATS));

    // Store beats into the next free slot; beats past capacity are dropped.
    always_ff @(posedge i_clk) begin
        if (wr_en && room) begin
            mem[cnt[BI_W-1:0]] <= wr_data;
        end
    end

    // Received-beat count, saturating at capacity, cleared per packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wr_en && room) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Halfword read: upper offset bits pick the beat, lower bits the slot.
    always_comb begin
        beat_sel = rd_offset[KEY_OFFSET_WIDTH-1:HW_W];
        hw_rev   = ~rd_offset[HW_W-1:0];
        rd_field = '0;
        if (CNT_W'(beat_sel) < cnt) begin
            rd_field = mem[beat_sel][hw_rev];
        end
    end

endmodule
`default_nettype wire

// File: rtl/parser_key_extract.sv
`default_nettype none
// ============================================================================
// Module  : parser_key_extract
// Purpose : Buffers a packet header, latches the lookup offset vector, then
//           extracts one key field per cycle and hands the key vector on with
//           a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module parser_key_extract
    import parser_pkg::*;
#(
    parameter int DATA_WIDTH       = 128,
    parameter int HDR_BEATS        = 8,
    parameter int KEY_FIELD_NUM    = 8,
    parameter int KEY_OFFSET_WIDTH = 6,
    parameter int FIELD_WIDTH      = 16
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic                                            i_hdr_valid,
    input  logic [DATA_WIDTH-1:0]                           i_hdr_data,
    input  logic                                            i_hdr_last,
    output logic                                            o_hdr_ready,
    input  logic                                            i_offset_valid,
    input  logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  i_offset,
    output logic                                            o_key_valid,
    output logic [KEY_FIELD_NUM-1:0][FIELD_WIDTH-1:0]       o_key,
    input  logic                                            i_key_ready,
    output logic                                            o_busy
);

    localparam int FC_W = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

    st_t                                            state;
    logic                                           off_ok;
    logic                                           hdr_done;
    logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] offs;
    logic [FC_W-1:0]                                fcnt;

    logic   beat_acc;
    logic   last_acc;
    logic   in_rx;
    logic   off_take;
    logic   hdr_done_nxt;
    logic   off_ok_nxt;
    logic   go_extract;
    logic   key_hs;
    field_t rd_field;

    // Header storage and halfword read port.
    parser_hdr_buf #(
        .DATA_WIDTH       (DATA_WIDTH),
        .HDR_BEATS        (HDR_BEATS),
        .FIELD_WIDTH      (FIELD_WIDTH),
        .KEY_OFFSET_WIDTH (KEY_OFFSET_WIDTH)
    ) u_hdr_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .clr       (key_hs),
        .wr_en     (beat_acc),
        .wr_data   (i_hdr_data),
        .rd_offset (offs[fcnt]),
        .rd_field  (rd_field)
    );

    assign o_busy = (state != ST_IDLE);

    // Header/offset arrival bookkeeping; both may land in the same cycle.
    always_comb begin
        beat_acc     = o_hdr_ready & i_hdr_valid;
        last_acc     = beat_acc & i_hdr_last;
        in_rx        = (state == ST_IDLE) || (state == ST_COLLECT);
        off_take     = in_rx & i_offset_valid & ~off_ok;
        hdr_done_nxt = hdr_done | last_acc;
        off_ok_nxt   = off_ok | off_take;
        go_extract   = in_rx & hdr_done_nxt & off_ok_nxt;
        key_hs       = (state == ST_OUTPUT) & i_key_ready;
    end

    // Main FSM with registered outputs, offset latch and field counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_hdr_ready <= 1'b0;
            o_key_valid <= 1'b0;
            o_key       <= '0;
            off_ok      <= 1'b0;
            hdr_done    <= 1'b0;
            offs        <= '0;
            fcnt        <= '0;
        end else begin
            // First offset vector wins until the packet completes.
            if (off_take) begin
                offs <= i_offset;
            end
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    off_ok   <= off_ok_nxt;
                    hdr_done <= hdr_done_nxt;
                    if (go_extract) begin
                        state       <= ST_EXTRACT;
                        fcnt        <= '0;
                        o_hdr_ready <= 1'b0;
                    end else begin
                        // Stop taking beats once the last one is in.
                        o_hdr_ready <= ~hdr_done_nxt;
                        if (beat_acc) begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_EXTRACT: begin
                    o_key[fcnt] <= rd_field;
                    fcnt        <= fcnt + 1'b1;
                    if (fcnt == FC_W'(KEY_FIELD_NUM - 1)) begin
                        state       <= ST_OUTPUT;
                        o_key_valid <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (i_key_ready) begin
                        state       <= ST_IDLE;
                        o_key_valid <= 1'b0;
                        o_hdr_ready <= 1'b1;
                        off_ok      <= 1'b0;
                        hdr_done    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parser_key_extract.sv
`default_nettype none
// ============================================================================
// Module  : tb_parser_key_extract
// Purpose : Self-checking bench for parser_key_extract (scoreboard of
//           expected key vectors built from a byte-level header model).
// Revision: 1.0 - initial release
// ============================================================================
module tb_parser_key_extract;

    typedef logic [7:0][15:0] key_t;
    typedef logic [7:0][5:0]  offv_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hdr_valid;
    logic [127:0] hdr_data;
    logic         hdr_last;
    logic         hdr_ready;
    logic         offset_valid;
    offv_t        offset;
    logic         key_valid;
    key_t         key;
    logic         key_ready;
    logic         busy;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] hb [0:159];
    key_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parser_key_extract dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_hdr_valid    (hdr_valid),
        .i_hdr_data     (hdr_data),
        .i_hdr_last     (hdr_last),
        .o_hdr_ready    (hdr_ready),
        .i_offset_valid (offset_valid),
        .i_offset       (offset),
        .o_key_valid    (key_valid),
        .o_key          (key),
        .i_key_ready    (key_ready),
        .o_busy         (busy)
    );

    // Byte-level reference: halfword k = bytes 2k,2k+1; zero if its beat was not received.
    function automatic key_t model(input offv_t o, input int nb);
        key_t r;
        int   k;
        for (int i = 0; i < 8; i++) begin
            k = int'(o[i]);
            if ((k / 16 * 2) >= nb * 2 || (k / 8) >= nb) r[i] = 16'h0;
            else r[i] = {hb[2*k], hb[2*k+1]};
        end
        return r;
    endfunction

    task automatic send_beat(input int b, input bit last, output int acc);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) d[(15-j)*8 +: 8] = hb[b*16+j];
        hdr_data  = d;
        hdr_last  = last;
        hdr_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            if (hdr_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++; n_bad++;
            $display("FAIL hdr_accept: beat %0d never accepted", b);
        end
        @(negedge clk);
        hdr_valid = 1'b0;
        hdr_last  = 1'b0;
    endtask

    task automatic pulse_offset(input offv_t v, output int t);
        offset       = v;
        offset_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        offset_valid = 1'b0;
    endtask

    task automatic collect_key(output key_t k, output int at, output bit ok);
        ok = 1'b0; at = -1; k = '0;
        for (int n = 0; n < 100; n++) begin
            if (key_valid === 1'b1) begin
                k = key; at = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hdr_valid = 0; hdr_data = '0; hdr_last = 0;
        offset_valid = 0; offset = '0; key_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (hdr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_hdr_ready: got %b want 0", hdr_ready); end
        n_vec++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
        n_vec++; if (key !== '0) begin n_bad++; $display("FAIL rst_key: got %h want 0", key); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (hdr_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_hdr_ready: got %b want 1", hdr_ready); end
    endtask

    task automatic test_basic();
        offv_t v; key_t k, e; int a, t, at; bit ok;
        for (int j = 0; j < 160; j++) hb[j] = 8'(j);
        for (int i = 0; i < 8; i++) v[i] = 6'(i);
        send_beat(0, 1'b0, a);
        send_beat(1, 1'b1, a);
        exp_q.push_back(model(v, 2));
        pulse_offset(v, t);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL basic_key: got %h want %h", k, e); end
        n_vec++; if (k[3] !== 16'h0607) begin n_bad++; $display("FAIL basic_key3: got %h want 0607", k[3]); end
        n_vec++; if (at - t != 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", at - t); end
        @(negedge clk);
    endtask

    task automatic test_offset_first();
        offv_t v; key_t k, e; int a, t, at; bit ok;
        for (int j = 0; j < 160; j++) hb[j] = 8'(j);
        v = '0; v[0] = 6'd9; v[1] = 6'd7; v[2] = 6'd1; v[3] = 6'd63;
        exp_q.push_back(model(v, 1));
        pulse_offset(v, t);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ofs_first_busy: got %b want 0", busy); end
        send_beat(0, 1'b1, a);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL ofs_first_key: got %h want %h", k, e); end
        n_vec++; if (k[0] !== 16'h0 || k[1] !== 16'h0E0F) begin n_bad++; $display("FAIL ofs_first_k01: got %h %h want 0000 0e0f", k[0], k[1]); end
        n_vec++; if (at - a != 9) begin n_bad++; $display("FAIL ofs_first_latency: got %0d want 9", at - a); end
        @(negedge clk);
    endtask

    task automatic test_long_header();
        offv_t v; key_t k, e; int a, t, at; bit ok;
        for (int j = 0; j < 160; j++) hb[j] = 8'((j * 7 + 3) ^ (j >> 4));
        v[0] = 6'd63; v[1] = 6'd56; v[2] = 6'd0; v[3] = 6'd8;
        v[4] = 6'd62; v[5] = 6'd31; v[6] = 6'd40; v[7] = 6'd57;
        for (int b = 0; b < 10; b++) begin
            if (b >= 8) begin
                n_vec++; if (hdr_ready !== 1'b1) begin n_bad++; $display("FAIL long_ready_beat%0d: got %b want 1", b, hdr_ready); end
            end
            send_beat(b, b == 9, a);
        end
        n_vec++; if (hdr_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL long_wait: ready %b busy %b want 0 1", hdr_ready, busy); end
        exp_q.push_back(model(v, 10));
        pulse_offset(v, t);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL long_key: got %h want %h", k, e); end
        n_vec++; if (at - t != 9) begin n_bad++; $display("FAIL long_latency: got %0d want 9", at - t); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        offv_t v; key_t k, e, k0; int a, t, at; bit ok;
        for (int j = 0; j < 160; j++) hb[j] = 8'(8'hA0 + j);
        v[0] = 6'd3; v[1] = 6'd2; v[2] = 6'd1; v[3] = 6'd0;
        v[4] = 6'd7; v[5] = 6'd6; v[6] = 6'd5; v[7] = 6'd4;
        key_ready = 1'b0;
        exp_q.push_back(model(v, 1));
        pulse_offset(v, t);
        send_beat(0, 1'b1, a);
        collect_key(k0, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k0 !== e) begin n_bad++; $display("FAIL bp_key: got %h want %h", k0, e); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++; if (key !== e || key_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_c%0d: key %h valid %b want %h 1", c, key, key_valid, e); end
            n_vec++; if (hdr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_c%0d: got %b want 0", c, hdr_ready); end
        end
        key_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (key_valid !== 1'b0 || hdr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: valid %b ready %b want 0 1", key_valid, hdr_ready); end
        // Next packet: single beat with same-cycle offset right after the handshake.
        for (int j = 0; j < 160; j++) hb[j] = 8'(8'h55 ^ j);
        v[0] = 6'd7; v[1] = 6'd0; v[2] = 6'd5; v[3] = 6'd9;
        exp_q.push_back(model(v, 1));
        offset = v; offset_valid = 1'b1;
        send_beat(0, 1'b1, a);
        offset_valid = 1'b0;
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (a < 0 || !ok || k !== e) begin n_bad++; $display("FAIL bp_next_key: got %h want %h", k, e); end
        n_vec++; if (at - a != 9) begin n_bad++; $display("FAIL bp_next_latency: got %0d want 9", at - a); end
        @(negedge clk);
    endtask

    task automatic test_double_offset();
        offv_t va, vb; key_t k, e; int a, t, at; bit ok;
        for (int j = 0; j < 160; j++) hb[j] = 8'(8'hF0 - j);
        for (int i = 0; i < 8; i++) begin va[i] = 6'(15 - i); vb[i] = 6'(i); end
        send_beat(0, 1'b0, a);
        exp_q.push_back(model(va, 2));
        pulse_offset(va, t);
        pulse_offset(vb, t);
        send_beat(1, 1'b1, a);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL dbl_key: got %h want %h", k, e); end
        n_vec++; if (at - a != 9) begin n_bad++; $display("FAIL dbl_latency: got %0d want 9", at - a); end
        @(negedge clk);
        // Lookup miss: all-zero offsets select halfword 0 everywhere.
        for (int j = 0; j < 160; j++) hb[j] = 8'(8'h3C + 3 * j);
        vb = '0;
        send_beat(0, 1'b1, a);
        exp_q.push_back(model(vb, 1));
        pulse_offset(vb, t);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL miss_key: got %h want %h", k, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        offv_t v; key_t k, e; int a, t, at; bit ok; bit stale;
        for (int j = 0; j < 160; j++) hb[j] = 8'(j + 1);
        for (int i = 0; i < 8; i++) v[i] = 6'(i + 1);
        offset = v; offset_valid = 1'b1;
        send_beat(0, 1'b1, a);
        offset_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (key_valid !== 1'b0 || key !== '0) begin n_bad++; $display("FAIL midrst_key: valid %b key %h want 0 0", key_valid, key); end
        n_vec++; if (busy !== 1'b0 || hdr_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_ready: busy %b ready %b want 0 0", busy, hdr_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 160; j++) hb[j] = 8'(8'hC3 ^ (5 * j));
        send_beat(0, 1'b1, a);
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (key_valid !== 1'b0 || busy !== 1'b1) stale = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (stale) begin n_bad++; $display("FAIL midrst_stale_offset: got extraction without offset want wait"); end
        for (int i = 0; i < 8; i++) v[i] = 6'(7 - i);
        exp_q.push_back(model(v, 1));
        pulse_offset(v, t);
        collect_key(k, at, ok);
        e = exp_q.pop_front();
        n_vec++; if (!ok || k !== e) begin n_bad++; $display("FAIL midrst_next_key: got %h want %h", k, e); end
        n_vec++; if (at - t != 9) begin n_bad++; $display("FAIL midrst_latency: got %0d want 9", at - t); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_first();
        test_long_header();
        test_backpressure();
        test_double_offset();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
